// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - types and constants shared by the dispatcher and worker controllers
package disp_pkg;

    // Default row-index width used by the dispatcher and every worker controller
    localparam int DEF_ROW_W   = 10;

    // Number of worker controllers hanging off one dispatcher
    localparam int NUM_WORKERS = 16;

    // Worker controller job phases
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        REPORT = 2'd3
    } mc_state_t;

endpackage

// File: rtl/mc_watchdog.sv
// rtl/mc_watchdog.sv - cycle watchdog with clear, enable and terminal-count flag
module mc_watchdog #(
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tc
);

    // One spare bit so the compare value TIMEOUT_CYC-1 always fits
    localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;

    logic [WD_W-1:0] r_count;

    // Count enabled cycles; clear has priority so a fresh job always starts at zero
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Terminal count: the cycle in which this job has spent TIMEOUT_CYC cycles running
    assign o_tc = (r_count == WD_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/worker_mc.sv
// rtl/worker_mc.sv - per-worker master controller between dispatcher, Julia worker and frame writer
module worker_mc
    import disp_pkg::*;
#(
    parameter int ROW_W       = DEF_ROW_W,
    parameter int TIMEOUT_CYC = 4096,
    parameter int CNT_W       = 16
) (
    input  logic             wr_clk,
    input  logic             wr_rst,
    input  logic             wr_start,
    input  logic [ROW_W-1:0] wr_row,
    output logic             wr_done,
    output logic             jw_begin,
    output logic [ROW_W-1:0] jw_row,
    input  logic             jw_done,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ROW_W-1:0] res_row,
    output logic             res_timeout,
    output logic             err_overrun,
    output logic [CNT_W-1:0] jobs_done
);

    mc_state_t        r_state;
    mc_state_t        w_state_nxt;
    logic             w_tc;
    logic             w_accept;
    logic             w_overrun;
    logic             w_run_exit;
    logic             w_handshake;

    logic             r_wr_done;
    logic             r_jw_begin;
    logic             r_res_valid;
    logic             r_res_timeout;
    logic             r_err_overrun;
    logic [ROW_W-1:0] r_row;
    logic [CNT_W-1:0] r_jobs;

    mc_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .i_clk    (wr_clk),
        .i_rst    (wr_rst),
        .i_clear  (r_state == LAUNCH),
        .i_enable (r_state == RUN),
        .o_tc     (w_tc)
    );

    // Next-state decode and the per-cycle events that drive the registered datapath
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_overrun   = 1'b0;
        w_run_exit  = 1'b0;
        w_handshake = 1'b0;
        case (r_state)
            IDLE: begin
                if (wr_start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                w_overrun   = wr_start;
                w_state_nxt = RUN;
            end
            RUN: begin
                w_overrun = wr_start;
                if (jw_done || w_tc) begin
                    w_run_exit  = 1'b1;
                    w_state_nxt = REPORT;
                end
            end
            REPORT: begin
                w_overrun = wr_start;
                if (res_ready) begin
                    w_handshake = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register plus registered outputs decoded from the next state
    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            r_state       <= IDLE;
            r_wr_done     <= 1'b1;
            r_jw_begin    <= 1'b0;
            r_res_valid   <= 1'b0;
            r_res_timeout <= 1'b0;
            r_err_overrun <= 1'b0;
            r_row         <= '0;
            r_jobs        <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_wr_done   <= (w_state_nxt == IDLE);
            r_jw_begin  <= (w_state_nxt == LAUNCH);
            r_res_valid <= (w_state_nxt == REPORT);
            if (w_accept) begin
                r_row         <= wr_row;
                r_res_timeout <= 1'b0;
            end
            // jw_done wins over the terminal count when both land together
            if (w_run_exit) begin
                r_res_timeout <= !jw_done;
            end
            if (w_overrun) begin
                r_err_overrun <= 1'b1;
            end
            if (w_handshake) begin
                r_jobs <= r_jobs + 1'b1;
            end
        end
    end

    assign wr_done     = r_wr_done;
    assign jw_begin    = r_jw_begin;
    assign jw_row      = r_row;
    assign res_valid   = r_res_valid;
    assign res_row     = r_row;
    assign res_timeout = r_res_timeout;
    assign err_overrun = r_err_overrun;
    assign jobs_done   = r_jobs;

endmodule
